// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO sizing defaults and depth derivation.
package fifo_pkg;
    localparam int DEF_WORDSIZE = 8;
    localparam int DEF_ADDRSIZE = 3;
    localparam int DEPTH = 1 << DEF_ADDRSIZE;

    function automatic int fifo_depth(input int addrsize);
        return 1 << addrsize;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: FIFO storage array, synchronous write gated by full, combinational read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WORDSIZE = DEF_WORDSIZE,
    parameter int ADDRSIZE = DEF_ADDRSIZE
) (
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [WORDSIZE-1:0] rdata,
    input  logic [WORDSIZE-1:0] wdata,
    input  logic                full,
    input  logic                clk,
    input  logic                rst
);
    localparam int NWORDS = fifo_depth(ADDRSIZE);

    logic [WORDSIZE-1:0] mem_q [NWORDS];
    logic [WORDSIZE-1:0] mem_d [NWORDS];

    // Every non-full cycle writes; there is no separate write enable.
    always_comb begin
        mem_d = mem_q;
        if (!full) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) mem_q <= '{default: '0};
        else     mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: tb/tb_fifo_mem.sv
// tb_fifo_mem: scoreboard bench for fifo_mem at default and overridden sizes.
module tb_fifo_mem;
    logic clk = 1'b0;
    always #100 clk = ~clk;

    logic [2:0]  waddr_a, raddr_a;
    logic [7:0]  wdata_a, rdata_a;
    logic        full_a, rst_a;
    logic [3:0]  waddr_b, raddr_b;
    logic [15:0] wdata_b, rdata_b;
    logic        full_b, rst_b;

    fifo_mem dut_a (
        .waddr(waddr_a), .raddr(raddr_a), .rdata(rdata_a), .wdata(wdata_a),
        .full(full_a), .clk(clk), .rst(rst_a)
    );

    fifo_mem #(.WORDSIZE(16), .ADDRSIZE(4)) dut_b (
        .waddr(waddr_b), .raddr(raddr_b), .rdata(rdata_b), .wdata(wdata_b),
        .full(full_b), .clk(clk), .rst(rst_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  model_a [8];
    logic [15:0] model_b [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Update both models from the inputs presented this cycle, then take the edge.
    task automatic step();
        if (rst_a) foreach (model_a[i]) model_a[i] = '0;
        else if (!full_a) model_a[waddr_a] = wdata_a;
        if (rst_b) foreach (model_b[i]) model_b[i] = '0;
        else if (!full_b) model_b[waddr_b] = wdata_b;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input string tag, input logic [2:0] a);
        exp_q.push_back({24'd0, model_a[a]});
        raddr_a = a;
        #1;
        check(tag, {24'd0, rdata_a}, exp_q.pop_front());
    endtask

    task automatic rd_b(input string tag, input logic [3:0] a);
        exp_q.push_back({16'd0, model_b[a]});
        raddr_b = a;
        #1;
        check(tag, {16'd0, rdata_b}, exp_q.pop_front());
    endtask

    initial begin
        foreach (model_a[i]) model_a[i] = 'x;
        foreach (model_b[i]) model_b[i] = 'x;
        waddr_a = '0; raddr_a = '0; wdata_a = '0; full_a = 1'b0; rst_a = 1'b1;
        waddr_b = '0; raddr_b = '0; wdata_b = '0; full_b = 1'b0; rst_b = 1'b1;
        @(negedge clk);
        step();
        rst_a = 1'b0;
        rst_b = 1'b0;
        full_b = 1'b1;
        for (int i = 0; i < 8; i++) rd_a($sformatf("reset_a[%0d]", i), 3'(i));

        for (int i = 0; i < 8; i++) begin
            waddr_a = 3'(i);
            wdata_a = 8'(100 + i);
            step();
        end
        full_a = 1'b1;
        rd_a("fill_r2", 3'd2);
        check("fill_r2_const", {24'd0, rdata_a}, 32'd102);
        rd_a("fill_r3", 3'd3);
        check("fill_r3_const", {24'd0, rdata_a}, 32'd103);
        rd_a("fill_r4", 3'd4);
        check("fill_r4_const", {24'd0, rdata_a}, 32'd104);

        waddr_a = 3'd5;
        wdata_a = 8'hAA;
        step();
        step();
        rd_a("full_block", 3'd5);
        check("full_block_const", {24'd0, rdata_a}, 32'd105);
        full_a = 1'b0;
        step();
        full_a = 1'b1;
        rd_a("full_release", 3'd5);
        check("full_release_const", {24'd0, rdata_a}, 32'hAA);

        raddr_a = 3'd6;
        waddr_a = 3'd6;
        wdata_a = 8'd200;
        full_a = 1'b0;
        #1;
        check("rdw_before", {24'd0, rdata_a}, 32'd106);
        step();
        full_a = 1'b1;
        check("rdw_after", {24'd0, rdata_a}, 32'd200);
        for (int i = 0; i < 8; i++) rd_a($sformatf("pre_rst[%0d]", i), 3'(i));

        rst_a = 1'b1;
        full_a = 1'b0;
        waddr_a = 3'd1;
        wdata_a = 8'd55;
        step();
        rst_a = 1'b0;
        full_a = 1'b1;
        for (int i = 0; i < 8; i++) rd_a($sformatf("rst_clear[%0d]", i), 3'(i));
        check("rst_beats_write", {24'd0, rdata_a}, 32'd0);
        raddr_a = 3'd1;
        #1;
        check("rst_beats_write_a1", {24'd0, rdata_a}, 32'd0);

        full_a = 1'b0;
        waddr_a = 3'd3;
        wdata_a = 8'h5C;
        step();
        full_a = 1'b1;
        rd_a("resume_write", 3'd3);

        full_b = 1'b0;
        waddr_b = 4'd15;
        wdata_b = 16'hBEEF;
        step();
        waddr_b = 4'd0;
        wdata_b = 16'h1234;
        step();
        full_b = 1'b1;
        for (int i = 0; i < 16; i++) rd_b($sformatf("wide[%0d]", i), 4'(i));
        raddr_b = 4'd15;
        #1;
        check("wide_beef", {16'd0, rdata_b}, 32'hBEEF);
        raddr_b = 4'd0;
        #1;
        check("wide_1234", {16'd0, rdata_b}, 32'h1234);
        raddr_b = 4'd7;
        #1;
        check("wide_mid_zero", {16'd0, rdata_b}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
